// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants and encodings for the fetch/PC stage.
// Address width and reset PC defaults are shared with the instruction RAM.
package fetch_pc_unit_pkg;

    localparam int              PC_W           = 16;
    localparam int              ADDR_WIDTH_DEF = 16;
    localparam logic [PC_W-1:0] RESET_PC_DEF   = 16'h0000;
    localparam logic [PC_W-1:0] INSTR_WAIT     = 16'h0000;

    typedef enum logic {
        PC_INC  = 1'b0,
        PC_ADDK = 1'b1
    } pc_sel_e;

    typedef enum logic [1:0] {
        UPD_HOLD,
        UPD_INC,
        UPD_ADDK,
        UPD_JUMP
    } pc_upd_e;

    function automatic logic [PC_W-1:0] addr_mask(input int aw);
        return (aw >= PC_W) ? {PC_W{1'b1}} : PC_W'((32'd1 << aw) - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Control/data bundle between the control FSM, instruction RAM and fetch stage.
// History read port exists only when PC_HISTORY_EN is defined.
interface fetch_pc_unit_if
`ifdef PC_HISTORY_EN
    #(parameter int HIST_DEPTH = 4)
`endif
    ;

    logic        pc_en;
    logic        pc_mux_selct;
    logic [15:0] pc_add_k;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic        ir_load;
    logic [15:0] mem_dout;
    logic [15:0] pc;
    logic [15:0] instr_set;
    logic [15:0] link_pc;
    logic        redirect;

`ifdef PC_HISTORY_EN
    localparam int HIST_IW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    logic [HIST_IW-1:0] hist_idx;
    logic [15:0]        hist_pc;

    modport master (
        output pc_en, pc_mux_selct, pc_add_k, jump_en, jump_addr, ir_load, mem_dout, hist_idx,
        input  pc, instr_set, link_pc, redirect, hist_pc
    );

    modport slave (
        input  pc_en, pc_mux_selct, pc_add_k, jump_en, jump_addr, ir_load, mem_dout, hist_idx,
        output pc, instr_set, link_pc, redirect, hist_pc
    );
`else
    modport master (
        output pc_en, pc_mux_selct, pc_add_k, jump_en, jump_addr, ir_load, mem_dout,
        input  pc, instr_set, link_pc, redirect
    );

    modport slave (
        input  pc_en, pc_mux_selct, pc_add_k, jump_en, jump_addr, ir_load, mem_dout,
        output pc, instr_set, link_pc, redirect
    );
`endif

endinterface

// File: rtl/fetch_pc_unit_pc_history_buf.sv
// Circular buffer of PCs at which a taken branch or jump committed.
// Read index 0 returns the most recent entry; unwritten entries read as zero.
module pc_history_buf #(
    parameter int DEPTH = 4,
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [15:0]   wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [15:0]   rd_data
);

    logic [15:0]   entry [DEPTH];
    logic [IW-1:0] wptr;
    logic [IW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (wr_en) begin
            entry[wptr] <= wr_data;
            wptr        <= wptr + IW'(1);
        end
    end

    // DEPTH is a power of two, so IW-bit arithmetic gives the modulo wrap for free.
    assign rd_ptr  = wptr - IW'(1) - rd_idx;
    assign rd_data = entry[rd_ptr];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: program counter, instruction register, link value and redirect pulse.
// Define PC_HISTORY_EN to add the taken-redirect history buffer and its read port.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [15:0] RESET_PC   = RESET_PC_DEF,
    parameter int          HIST_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    fetch_pc_unit_if.slave  bus
);

    localparam logic [15:0] ADDR_MASK = addr_mask(ADDR_WIDTH);

    if (HIST_DEPTH < 1 || (HIST_DEPTH & (HIST_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("HIST_DEPTH must be a power of two");
    end

    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] ir_q;
    logic        redirect_q;
    logic        taken;
    pc_upd_e     upd;

    always_comb begin
        upd = UPD_HOLD;
        if (bus.pc_en) begin
            if (bus.jump_en) begin
                upd = UPD_JUMP;
            end else if (pc_sel_e'(bus.pc_mux_selct) == PC_ADDK) begin
                upd = UPD_ADDK;
            end else begin
                upd = UPD_INC;
            end
        end
    end

    always_comb begin
        pc_d = pc_q;
        case (upd)
            UPD_INC:  pc_d = (pc_q + 16'd1) & ADDR_MASK;
            UPD_ADDK: pc_d = (pc_q + bus.pc_add_k) & ADDR_MASK;
            UPD_JUMP: pc_d = bus.jump_addr & ADDR_MASK;
            default:  pc_d = pc_q;
        endcase
    end

    assign taken = bus.pc_en & (bus.jump_en | bus.pc_mux_selct);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC & ADDR_MASK;
            ir_q       <= INSTR_WAIT;
            redirect_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= taken;
            if (bus.ir_load) begin
                ir_q <= bus.mem_dout;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.instr_set = ir_q;
    assign bus.redirect  = redirect_q;
    assign bus.link_pc   = (pc_q + 16'd1) & ADDR_MASK;

`ifdef PC_HISTORY_EN
    // Records the pre-update PC, i.e. the address of the branch/jump itself.
    pc_history_buf #(
        .DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (taken),
        .wr_data (pc_q),
        .rd_idx  (bus.hist_idx),
        .rd_data (bus.hist_pc)
    );
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit at ADDR_WIDTH=10: directed literal checks plus random
// stimulus compared every cycle against an arithmetic/queue reference model.
module tb_fetch_pc_unit;

    localparam int AW  = 10;
    localparam int M   = 1 << AW;
    localparam int HD  = 4;
    localparam int HIW = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;

`ifdef PC_HISTORY_EN
    fetch_pc_unit_if #(.HIST_DEPTH(HD)) bus();
`else
    fetch_pc_unit_if bus();
`endif

    fetch_pc_unit #(
        .ADDR_WIDTH (AW),
        .RESET_PC   (16'h0000),
        .HIST_DEPTH (HD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model: PC as an integer modulo 2^AW, history as a newest-first queue.
    int          m_pc;
    logic [15:0] m_ir;
    bit          m_red;
    int          m_hist[$];

    function automatic int wrap(input int v);
        return ((v % M) + M) % M;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc  = 0;
            m_ir  = 16'h0000;
            m_red = 1'b0;
            m_hist.delete();
        end else begin
            bit tk;
            tk = bus.pc_en && (bus.jump_en || bus.pc_mux_selct);
            if (tk) begin
                m_hist.push_front(m_pc);
                if (m_hist.size() > HD) void'(m_hist.pop_back());
            end
            if (bus.pc_en) begin
                if (bus.jump_en)           m_pc = wrap(int'(bus.jump_addr));
                else if (bus.pc_mux_selct) m_pc = wrap(m_pc + int'($signed(bus.pc_add_k)));
                else                       m_pc = wrap(m_pc + 1);
            end
            if (bus.ir_load) m_ir = bus.mem_dout;
            m_red = tk;
        end
    end

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("model_pc",       bus.pc,        16'(m_pc));
            cmp("model_instr",    bus.instr_set, m_ir);
            cmp("model_link_pc",  bus.link_pc,   16'(wrap(m_pc + 1)));
            cmp("model_redirect", {15'd0, bus.redirect}, {15'd0, m_red});
`ifdef PC_HISTORY_EN
            begin
                int idx;
                idx = int'(bus.hist_idx);
                cmp("model_hist_pc", bus.hist_pc,
                    (idx < m_hist.size()) ? 16'(m_hist[idx]) : 16'h0000);
            end
`endif
        end
    end

    task automatic drive(input bit en, input bit sel, input logic [15:0] k,
                         input bit jen, input logic [15:0] ja,
                         input bit irl, input logic [15:0] md);
        bus.pc_en        = en;
        bus.pc_mux_selct = sel;
        bus.pc_add_k     = k;
        bus.jump_en      = jen;
        bus.jump_addr    = ja;
        bus.ir_load      = irl;
        bus.mem_dout     = md;
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFF);
`ifdef PC_HISTORY_EN
        bus.hist_idx = '0;
`endif
        repeat (3) cyc();
        chk_on = 1'b1;
        cmp("reset_pc",       bus.pc, 16'h0000);
        cmp("reset_instr",    bus.instr_set, 16'h0000);
        cmp("reset_redirect", {15'd0, bus.redirect}, 16'h0000);

        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        reset = 1'b1;
        cyc();
        cmp("first_edge_inc", bus.pc, 16'h0001);

        drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0000);
        cyc();
        drive(1'b1, 1'b1, 16'hFFFC, 1'b0, 16'h0000, 1'b0, 16'h0000);
        cyc();
        cmp("branch_back4",   bus.pc, 16'h000C);
        cmp("branch_redir",   {15'd0, bus.redirect}, 16'h0001);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        cyc();
        cmp("inc_after_br",   bus.pc, 16'h000D);
        cmp("redir_one_cyc",  {15'd0, bus.redirect}, 16'h0000);

        drive(1'b0, 1'b1, 16'h0005, 1'b1, 16'h0123, 1'b0, 16'h0000);
        cyc();
        cmp("hold_ignores_jump", bus.pc, 16'h000D);
        cmp("hold_no_redir",     {15'd0, bus.redirect}, 16'h0000);
        drive(1'b1, 1'b1, 16'h0005, 1'b1, 16'h0123, 1'b0, 16'h0000);
        cyc();
        cmp("jump_priority",  bus.pc, 16'h0123);

        drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h03FF, 1'b0, 16'h0000);
        cyc();
        cmp("link_at_top",    bus.link_pc, 16'h0000);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        cyc();
        cmp("wrap_forward",   bus.pc, 16'h0000);
        drive(1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'h0000);
        cyc();
        cmp("wrap_backward",  bus.pc, 16'h03FF);
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'hF005, 1'b0, 16'h0000);
        cyc();
        cmp("jump_high_drop", bus.pc, 16'h0005);

        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h5A12);
        cyc();
        cmp("ir_capture",     bus.instr_set, 16'h5A12);
        cmp("ir_with_inc",    bus.pc, 16'h0006);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hBEEF);
        cyc();
        cmp("ir_hold",        bus.instr_set, 16'h5A12);
        drive(1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        cyc();
        cmp("self_loop",      bus.pc, 16'h0006);
        cmp("self_loop_redir", {15'd0, bus.redirect}, 16'h0001);

`ifdef PC_HISTORY_EN
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000);
        cyc();
        drive(1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h0000);
        repeat (5) cyc();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        cyc();
        for (int i = 0; i < HD; i++) begin
            logic [15:0] exp_h;
            exp_h = 16'(5 - i);
            bus.hist_idx = HIW'(i);
            #1;
            cmp("hist_read", bus.hist_pc, exp_h);
        end
`endif

        for (int c = 0; c < 3000; c++) begin
            logic [15:0] k;
            if ($urandom_range(0, 1) == 0) k = 16'($urandom_range(0, 15)) - 16'd8;
            else                           k = 16'($urandom);
            drive($urandom_range(0, 3) != 0, 1'($urandom), k,
                  $urandom_range(0, 5) == 0, 16'($urandom),
                  1'($urandom), 16'($urandom));
`ifdef PC_HISTORY_EN
            bus.hist_idx = HIW'($urandom_range(0, HD - 1));
`endif
            if (c == 1500) begin
                #2 reset = 1'b0;
                repeat (2) cyc();
                reset = 1'b1;
            end
            cyc();
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
